// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: sample enable and raw buttons in, clean levels and move pulses out.
// The conditioner sits on the slave side.
interface btn_conditioner_if #(
  parameter int N_BTN = 4
);
  logic             tick;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (output tick, output btn_raw, input btn_level, input btn_pulse);
  modport slave  (input tick, input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchronizer, tick-based debounce and hold-to-repeat pulse generator.
// Bit order {right, left, down, up}; every button runs its own FSM and counter.
module btn_conditioner #(
  parameter int N_BTN      = 4,
  parameter int DB_TICKS   = 20,
  parameter int RPT_DELAY  = 300,
  parameter int RPT_PERIOD = 100,
  parameter int CW         = 10
) (
  input  logic               clk,
  input  logic               rst,
  btn_conditioner_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CHK,
    HELD_DLY,
    HELD_RPT,
    REL_CHK
  } state_t;

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] pulse_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_q;
    logic          level_nxt;
    logic          pulse_q;
    logic          pulse_nxt;
    logic          s;

    assign s = sync2[i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= IDLE;
        cnt     <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        pulse_q <= pulse_nxt;
      end
    end

    // A change of the synchronized level acts immediately; counting only happens on tick.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level_q;
      pulse_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (bus.tick) begin
            if (cnt == DB_LAST) begin
              state_nxt = HELD_DLY;
              cnt_nxt   = '0;
              level_nxt = 1'b1;
              pulse_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        HELD_DLY: begin
          if (!s) begin
            state_nxt = REL_CHK;
            cnt_nxt   = '0;
          end else if (bus.tick && (RPT_DELAY != 0)) begin
            if (cnt == DLY_LAST) begin
              state_nxt = HELD_RPT;
              cnt_nxt   = '0;
              pulse_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        HELD_RPT: begin
          if (!s) begin
            state_nxt = REL_CHK;
            cnt_nxt   = '0;
          end else if (bus.tick) begin
            if (cnt == PER_LAST) begin
              cnt_nxt   = '0;
              pulse_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        REL_CHK: begin
          // Bouncing back high restarts the repeat delay without a new press pulse.
          if (s) begin
            state_nxt = HELD_DLY;
            cnt_nxt   = '0;
          end else if (bus.tick) begin
            if (cnt == DB_LAST) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
              level_nxt = 1'b0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end
      endcase
    end

    assign level_vec[i] = level_q;
    assign pulse_vec[i] = pulse_q;
  end

  assign bus.btn_level = level_vec;
  assign bus.btn_pulse = pulse_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: directed vector table, corner-case sequences and a
// randomized run, all checked against an event-level reference model of the button rules.
module tb_btn_conditioner;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN(N), .DB_TICKS(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .CW(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] pul;
  } vec_t;

  vec_t tbl[20];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw samples delayed two clocks, run length of the current
  // synchronized level in ticks, accepted level, and ticks held since the hold (re)started.
  bit           m_s1[N];
  bit           m_s2[N];
  bit           m_last[N];
  bit           m_lvl[N];
  int           m_run[N];
  int           m_hold[N];
  logic [N-1:0] exp_level;
  logic [N-1:0] exp_pulse;
  int           edge_no;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_last[i] = 0; m_lvl[i] = 0;
      m_run[i] = 0; m_hold[i] = 0;
    end
    exp_level = '0;
    exp_pulse = '0;
  endfunction

  function automatic void model_step(logic [N-1:0] raw, logic t);
    exp_pulse = '0;
    for (int i = 0; i < N; i++) begin
      bit s;
      s = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
      if (s != m_last[i]) begin
        m_run[i] = 0;
        if (s && m_lvl[i]) m_hold[i] = 0;
      end else if (t) begin
        m_run[i]++;
        if (!m_lvl[i] && s && m_run[i] == DB) begin
          m_lvl[i] = 1; m_hold[i] = 0; exp_pulse[i] = 1'b1;
        end else if (m_lvl[i] && !s && m_run[i] == DB) begin
          m_lvl[i] = 0;
        end else if (m_lvl[i] && s) begin
          m_hold[i]++;
          if (RD != 0 && m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) exp_pulse[i] = 1'b1;
        end
      end
      m_last[i] = s;
      exp_level[i] = m_lvl[i];
    end
  endfunction

  task automatic check_output(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_no, act, exp);
    end
  endtask

  // Called in the low clock phase; returns in the next low phase.
  task automatic apply_stimulus(logic [N-1:0] raw, logic t);
    bus.btn_raw = raw;
    bus.tick    = t;
    @(posedge clk);
    edge_no++;
    if (rst) model_step(raw, t);
    else     model_reset();
    #1;
    check_output("model_level", bus.btn_level, exp_level);
    check_output("model_pulse", bus.btn_pulse, exp_pulse);
    @(negedge clk);
  endtask

  initial begin
    int pulse_cnt;
    int first_edge;
    logic [N-1:0] seen;
    logic [N-1:0] raw;

    tbl = '{
      '{4'h1, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h0},
      '{4'h1, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h0}, '{4'h1, 4'h1, 4'h1}, '{4'h1, 4'h1, 4'h0},
      '{4'h1, 4'h1, 4'h0}, '{4'h1, 4'h1, 4'h0}, '{4'h0, 4'h1, 4'h0}, '{4'h0, 4'h1, 4'h0},
      '{4'h0, 4'h1, 4'h0}, '{4'h0, 4'h1, 4'h0}, '{4'h0, 4'h1, 4'h0}, '{4'h0, 4'h1, 4'h0},
      '{4'h0, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0}
    };

    edge_no     = 0;
    bus.btn_raw = '0;
    bus.tick    = 1'b0;
    model_reset();
    #2;
    check_output("reset_level", bus.btn_level, '0);
    check_output("reset_pulse", bus.btn_pulse, '0);
    @(negedge clk);
    apply_stimulus('0, 1'b1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) apply_stimulus('0, 1'b1);

    // Basic press/release on bit 0, against the fixed vector table.
    $display("[TB] directed press/release");
    edge_no = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(tbl[i].raw, 1'b1);
      check_output("tbl_level", bus.btn_level, tbl[i].lvl);
      check_output("tbl_pulse", bus.btn_pulse, tbl[i].pul);
    end
    for (int c = 0; c < 5; c++) apply_stimulus('0, 1'b1);

    // Bounce on bit 1 never long enough to qualify.
    $display("[TB] bounce");
    seen = '0;
    for (int c = 0; c < 40; c++) begin
      apply_stimulus((c < 30 && (c / 2) % 2 == 0) ? 4'h2 : 4'h0, 1'b1);
      seen = seen | bus.btn_pulse | bus.btn_level;
    end
    check_output("bounce_quiet", seen, '0);

    // Hold bit 2 for 40 clocks: press pulse at 7, then 15, 18, ... up to the FSM seeing release.
    $display("[TB] hold repeat");
    edge_no = 0; pulse_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      apply_stimulus(c < 40 ? 4'h4 : 4'h0, 1'b1);
      if (bus.btn_pulse[2]) pulse_cnt++;
    end
    check_output("hold_pulse_count", 4'(pulse_cnt), 4'd11);

    // Two-clock dropout at rise+12 restarts the repeat delay without a pulse.
    $display("[TB] release glitch");
    edge_no = 0;
    for (int c = 0; c < 50; c++) apply_stimulus((c == 11 || c == 12 || c >= 35) ? 4'h0 : 4'h4, 1'b1);
    for (int c = 0; c < 5; c++) apply_stimulus('0, 1'b1);

    // Asynchronous reset mid-hold on bit 3, then release with the button still pressed.
    $display("[TB] reset mid-hold");
    for (int c = 0; c < 10; c++) apply_stimulus(4'h8, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_level", bus.btn_level, '0);
    check_output("async_rst_pulse", bus.btn_pulse, '0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) apply_stimulus(4'h8, 1'b1);
    rst = 1'b1;
    edge_no = 0; first_edge = -1;
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(4'h8, 1'b1);
      if (bus.btn_pulse[3] && first_edge < 0) first_edge = edge_no;
    end
    check_output("rst_repress_edge", 4'(first_edge), 4'd7);
    for (int c = 0; c < 20; c++) apply_stimulus('0, 1'b1);

    // Bits 0 and 3 together with tick only every 5th clock.
    $display("[TB] sparse tick");
    edge_no = 0; first_edge = -1;
    for (int c = 0; c < 80; c++) begin
      apply_stimulus(c < 40 ? 4'h9 : 4'h0, (c % 5) == 4);
      if (bus.btn_pulse == 4'h9 && first_edge < 0) first_edge = edge_no;
    end
    check_output("sparse_pulse_edge", 5'(first_edge), 5'd20);

    // Randomized buttons and tick.
    $display("[TB] random");
    raw = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
      apply_stimulus(raw, (c < 2000) ? 1'b1 : 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input stage directly upstream of the game-logic controller: it takes the raw, asynchronous direction pushbuttons and produces clean, synchronous, debounced button levels plus single-cycle move pulses with hold-to-repeat. Each button gets its own synchronizer, debounce counter and state machine. All timing counts a sample-enable `tick` derived from the free-running clock divider, so the game logic runs on the system clock with enables instead of a divided clock.

## Interface
- `N_BTN`, 4: number of buttons; bit order {right, left, down, up} = [3:0].
- `DB_TICKS`, 20: stable ticks required to accept a press or a release (≥1).
- `RPT_DELAY`, 300: ticks from the accepted press to the first repeat pulse; 0 disables repeat.
- `RPT_PERIOD`, 100: ticks between repeat pulses (≥1).
- `CW`, 10: counter width; must hold max(DB_TICKS, RPT_DELAY, RPT_PERIOD).

- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `tick`  in  1  single-cycle sample enable (1 kHz nominal).
- `btn_raw`  in  N_BTN  raw pushbutton inputs, asynchronous, active-high.
- `btn_level`  out  N_BTN  debounced button state, registered.
- `btn_pulse`  out  N_BTN  one-clk pulse per accepted press and per repeat, registered.

## Operation
- Synchronizer: two flops per bit; `s[i]` is the second flop. All FSM decisions use `s[i]` only.
- Per-button FSM, states IDLE, PRESS_CHK, HELD_DLY, HELD_RPT, REL_CHK; one counter `cnt` (CW bits) per button:
  - IDLE: `s=1` → PRESS_CHK, cnt=0.
  - PRESS_CHK: `s=0` → IDLE. Otherwise on tick: if cnt==DB_TICKS-1 → HELD_DLY, cnt=0, level←1, pulse; else cnt++.
  - HELD_DLY: `s=0` → REL_CHK, cnt=0. Otherwise on tick, with RPT_DELAY≠0: if cnt==RPT_DELAY-1 → HELD_RPT, cnt=0, pulse; else cnt++. With RPT_DELAY=0, stays put and emits no repeat.
  - HELD_RPT: `s=0` → REL_CHK, cnt=0. Otherwise on tick: if cnt==RPT_PERIOD-1 → pulse, cnt=0; else cnt++.
  - REL_CHK: `s=1` → HELD_DLY, cnt=0 (repeat timing restarts, no pulse, level stays 1). Otherwise on tick: if cnt==DB_TICKS-1 → IDLE, level←0; else cnt++.
- Without tick, counters hold. A change of `s` acts on that clk regardless of tick.
- `btn_pulse[i]` is high for exactly one clk and is 0 in every cycle where no pulse event occurs.
- Buttons are fully independent. Simultaneous events on different bits pulse in the same cycle.
- Reset (`rst`=0): sync flops 0, all FSMs IDLE, cnt=0, `btn_level`=0, `btn_pulse`=0, applied immediately. A button still held when reset releases must pass full debounce before it pulses.

## Timing
- Latency with tick tied high: `btn_raw` rise sampled at edge 1; `s` high after edge 2; PRESS_CHK after edge 3; pulse/level visible after edge 3+DB_TICKS. Release: level falls DB_TICKS+3 clks after the `btn_raw` fall.
- First repeat follows the press pulse by RPT_DELAY ticks. Later repeats come every RPT_PERIOD ticks. With tick=1 and RPT_PERIOD=1, pulse stays high every cycle (legal).
- Counters never wrap: the terminal compare always resets cnt to 0 first.
- Throughput: any press sustained ≥DB_TICKS ticks yields ≥1 pulse; shorter presses yield none.

## Test plan
- Params DB_TICKS=4, RPT_DELAY=8, RPT_PERIOD=3, tick=1. Press `btn_raw[0]` and hold 10 clks, then release → one `btn_pulse[0]` 7 clks after the rise; `btn_level[0]` high from that clk until 7 clks after the release; no other bits toggle.
- Bounce: toggle `btn_raw[1]` every 2 clks for 30 clks, then hold low → `btn_pulse[1]`=0 and `btn_level[1]`=0 throughout.
- Hold `btn_raw[2]` for 40 clks → pulses at rise+7, +15, +18, +21, +24, … (every 3 clks) until release; none after the release.
- During a hold at rise+12, drive `btn_raw[2]` low for 2 clks → `btn_level` stays 1, no pulse; the next pulse comes 8 ticks after the FSM re-enters HELD_DLY.
- Assert `rst`=0 mid-hold on bit 3 → level/pulse go 0 without a clock edge. Release `rst` with the button still high → new pulse 7 clks later.
- `btn_raw[0]` and `btn_raw[3]` rise in the same clk, tick pulsed every 5th clk → both pulses appear in the same clk, level rises together, and counts advance only on tick clks.
